// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative signed 32-bit restoring divider. Takes operands on a
//            start pulse, runs one quotient bit per cycle for 32 cycles, then
//            applies signs and presents quotient (lo) and remainder (hi) with
//            a one-cycle done strobe. A zero divisor raises a one-cycle
//            exception strobe instead of starting.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        div_end,
    output logic        div_zero
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_FIX    = 2'd2;

    // Counter value on the 32nd (final) restoring step.
    localparam logic [4:0] c_LAST_STEP = 5'd31;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic        w_accept;      // start accepted with a non-zero divisor
    logic        w_zero_req;    // start requested with a zero divisor
    logic        w_step;        // perform one restoring step this cycle
    logic        w_fix;         // apply signs and publish result this cycle

    logic [31:0] r_qreg;        // dividend magnitude shifting out, quotient in
    logic [31:0] r_div;         // divisor magnitude
    logic [31:0] r_rem;         // partial remainder (always < r_div)
    logic [4:0]  r_cnt;         // restoring step counter
    logic        r_sign_q;      // quotient must be negated
    logic        r_sign_r;      // remainder must be negated

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_div_end;
    logic        r_div_zero;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_trial;
    logic        w_fits;
    logic [31:0] w_diff;
    logic [31:0] w_q_signed;
    logic [31:0] w_r_signed;

    // ------------------------------------------------------------------------
    // Operand magnitudes. 0x80000000 maps onto itself, which is the correct
    // unsigned magnitude, so no special case is needed for the most
    // negative value.
    // ------------------------------------------------------------------------
    assign w_a_mag = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag = b[31] ? (~b + 32'd1) : b;

    // ------------------------------------------------------------------------
    // Restoring step. Because the partial remainder is kept below the divisor,
    // the shifted trial value is below 2*divisor, so any successful difference
    // fits in 32 bits and only the comparison needs the 33rd bit.
    // ------------------------------------------------------------------------
    assign w_trial = {r_rem, r_qreg[31]};
    assign w_fits  = (w_trial >= {1'b0, r_div});
    assign w_diff  = w_trial[31:0] - r_div;

    // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
    assign w_q_signed = r_sign_q ? (32'd0 - r_qreg) : r_qreg;
    assign w_r_signed = r_sign_r ? (32'd0 - r_rem)  : r_rem;

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero_req  = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (div_start) begin
                    if (b == 32'd0) begin
                        w_zero_req = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == c_LAST_STEP) begin
                    w_state_nxt = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Iteration datapath: operand capture, restoring steps, step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_qreg   <= 32'd0;
            r_div    <= 32'd0;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (w_accept) begin
            r_qreg   <= w_a_mag;
            r_div    <= w_b_mag;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_sign_q <= a[31] ^ b[31];
            r_sign_r <= a[31];
        end else if (w_step) begin
            r_qreg <= {r_qreg[30:0], w_fits};
            r_rem  <= w_fits ? w_diff : w_trial[31:0];
            r_cnt  <= r_cnt + 5'd1;
        end
    end

    // Registered outputs: result, strobes and busy. Busy covers the strobe
    // cycle and drops on the edge after it, unless a new start arrives then.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_div_end  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_end  <= 1'b0;
            r_div_zero <= w_zero_req;
            if (r_div_end) begin
                r_busy <= 1'b0;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
            end
            if (w_fix) begin
                r_lo      <= w_q_signed;
                r_hi      <= w_r_signed;
                r_div_end <= 1'b1;
            end
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign div_end  = r_div_end;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit. Expected results are
//            queued when a division is started and popped when div_end fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_end;
    logic        div_zero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .div_end   (div_end),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negative edge; returns at a negative edge.
    // poke_at > 0 re-pulses div_start (a=1,b=1) that many edges after start.
    task automatic run_div(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int poke_at);
        exp_t e;
        int   n;
        bit   seen;
        bit   zero_seen;
        e.hi = exp_hi;
        e.lo = exp_lo;
        sb.push_back(e);
        a = aa;
        b = bb;
        div_start = 1'b1;
        @(posedge clk);                       // E0
        @(negedge clk);
        div_start = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        seen = 1'b0;
        zero_seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == poke_at) begin
                div_start = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end else begin
                div_start = 1'b0;
            end
            if (div_zero) zero_seen = 1'b1;
            if (div_end) seen = 1'b1;
        end
        div_start = 1'b0;
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_div_zero"}, {31'd0, zero_seen}, 32'd0);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_lo"}, lo, e.lo);
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_busy_at_end"}, {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_end_drop"}, {31'd0, div_end}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    // Watches for any strobe over a window; returns at a negative edge.
    task automatic quiet_window(input string tag, input int cycles);
        bit strobe;
        strobe = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (div_end || div_zero || busy) strobe = 1'b1;
        end
        check({tag, "_quiet"}, {31'd0, strobe}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        div_start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_flags", {29'd0, busy, div_end, div_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_div("d7_2",    32'd7,          32'd2,          32'h00000003, 32'h00000001, 0);
        run_div("dm7_2",   32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_div("d7_m2",   32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 0);
        run_div("dmin_m1", 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 0);
        run_div("dm100_m7",32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 0);
        run_div("dmax_1",  32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 32'h00000000, 0);
        run_div("d100_7",  32'd100,        32'd7,          32'd14,       32'd2,        0);

        // Divide by zero: one-cycle exception strobe, nothing else changes.
        a = 32'd5;
        b = 32'd0;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        check("dz_strobe", {31'd0, div_zero}, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("dz_strobe_drop", {31'd0, div_zero}, 32'd0);
        quiet_window("dz", 40);
        check("dz_hi_hold", hi, 32'd2);
        check("dz_lo_hold", lo, 32'd14);

        // Reset mid-operation aborts without any strobe.
        a = 32'd1000;
        b = 32'd3;
        div_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_flags", {29'd0, busy, div_end, div_zero}, 32'd0);
        quiet_window("abort", 40);
        run_div("d9_4", 32'd9, 32'd4, 32'd2, 32'd1, 0);

        // Reset and start in the same cycle: the start is dropped.
        reset = 1'b1;
        div_start = 1'b1;
        a = 32'd9;
        b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        div_start = 1'b0;
        check("rst_start_busy", {31'd0, busy}, 32'd0);
        quiet_window("rst_start", 40);

        // A second start while busy is ignored.
        run_div("d20_6_poke", 32'd20, 32'd6, 32'd3, 32'd2, 5);
        quiet_window("poke", 40);

        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
